// File: rtl/dottori_video_gen_if.sv
// dottori_video_gen_if
// VRAM fetch bus between the video generator and the board-level VRAM mux.
//   vram_addr  render fetch address (driven by the video generator)
//   vram_sel   high in a fetch-slot cycle; the bus mux selects vram_addr
//   cpu_stall  copy of vram_sel, gates the Z80 clock
//   vram_q     RAM read data, valid the cycle after vram_sel
// Modports: master = video generator side, slave = RAM / bus mux side.
interface dottori_video_gen_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_sel;
    logic              cpu_stall;
    logic [7:0]        vram_q;

    modport master (
        output vram_addr,
        output vram_sel,
        output cpu_stall,
        input  vram_q
    );

    modport slave (
        input  vram_addr,
        input  vram_sel,
        input  cpu_stall,
        output vram_q
    );
endinterface

// File: rtl/dottori_video_gen.sv
// dottori_video_gen
// Raster timing generator plus VRAM fetch and pixel serialiser for
// Dottori-class boards. Produces counters, sync, blanking, a one-line V-blank
// interrupt and palette-mapped RGB. Each fetch slot owns VRAM for one cycle
// and stalls the Z80 for that cycle.
// Ports:
//   nCLK_4M   clock, rising edge
//   nRESET    asynchronous, active-low reset
//   vbus      VRAM fetch bus (master side): vram_addr/vram_sel/cpu_stall out,
//             vram_q in
//   pal_wr    palette write strobe; pal_data is captured on that edge
//   pal_data  2^BPP palette entries, entry i = bits [3i+2:3i], {B,G,R}
//   rgb       pixel colour {B,G,R}, 0 while blanked
//   hsync, vsync, csync_n, hblank, vblank  raster timing flags
//   irq_n     active-low V-blank interrupt, low for one line
//   hcnt, vcnt  raster position
module dottori_video_gen #(
    parameter int H_TOTAL      = 256,
    parameter int H_ACTIVE     = 128,
    parameter int H_SYNC_START = 192,
    parameter int H_SYNC_LEN   = 16,
    parameter int V_TOTAL      = 256,
    parameter int V_ACTIVE     = 128,
    parameter int V_SYNC_START = 224,
    parameter int V_SYNC_LEN   = 8,
    parameter int BPP          = 1,
    parameter int PIX_REP      = 1,
    parameter int ADDR_W       = 11
) (
    input  logic                           nCLK_4M,
    input  logic                           nRESET,
    dottori_video_gen_if.master            vbus,
    input  logic                           pal_wr,
    input  logic [3*(2**BPP)-1:0]          pal_data,
    output logic [2:0]                     rgb,
    output logic                           hsync,
    output logic                           vsync,
    output logic                           csync_n,
    output logic                           hblank,
    output logic                           vblank,
    output logic                           irq_n,
    output logic [$clog2(H_TOTAL)-1:0]     hcnt,
    output logic [$clog2(V_TOTAL)-1:0]     vcnt
);
    localparam int P     = (8 / BPP) * PIX_REP;
    localparam int PAL_W = 3 * (2**BPP);
    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);

    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d, vcnt_next_line;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_out;
    logic              load_q, load_d;
    logic              rep_q, rep_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [PAL_W-1:0]  pal_q, pal_d;
    logic              irq_n_q, irq_n_d;

    logic              hcnt_wrap;
    int                tgt_h, tgt_col, tgt_line;
    logic              slot, first_slot, rep_last;
    logic [BPP-1:0]    pix_idx;

    // Raster counters: hcnt free-runs over the line, vcnt advances on its wrap.
    always_comb begin
        hcnt_wrap      = (hcnt_q == HW'(H_TOTAL - 1));
        hcnt_d         = hcnt_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_next_line = (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
        vcnt_d         = hcnt_wrap ? vcnt_next_line : vcnt_q;
    end

    // Fetch slots look two clocks ahead so the byte is in the shifter exactly
    // when hcnt reaches its first column; targets past the line end belong to
    // the start of the next line.
    always_comb begin
        tgt_h      = int'(hcnt_q) + 2;
        tgt_col    = tgt_h;
        tgt_line   = int'(vcnt_q);
        if (tgt_h >= H_TOTAL) begin
            tgt_col  = tgt_h - H_TOTAL;
            tgt_line = int'(vcnt_next_line);
        end
        slot       = ((tgt_col % P) == 0) && (tgt_col < H_ACTIVE) && (tgt_line < V_ACTIVE);
        first_slot = slot && (tgt_col == 0) && (tgt_line == 0);
        addr_out   = first_slot ? '0 : addr_q;
        addr_d     = slot ? addr_out + 1'b1 : addr_q;
        load_d     = slot;
    end

    // Shifter: load one cycle after the slot (RAM latency), then shift every
    // PIX_REP clocks; with no further loads it drains to zero.
    always_comb begin
        rep_last = (PIX_REP == 1) || rep_q;
        shreg_d  = shreg_q;
        rep_d    = 1'b0;
        if (load_q) begin
            shreg_d = vbus.vram_q;
        end else if (rep_last) begin
            shreg_d = shreg_q << BPP;
        end else begin
            rep_d = 1'b1;
        end
        pal_d   = pal_wr ? pal_data : pal_q;
        irq_n_d = (int'(vcnt_d) != V_ACTIVE);
    end

    always_ff @(posedge nCLK_4M or negedge nRESET) begin
        if (!nRESET) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            addr_q  <= '0;
            load_q  <= 1'b0;
            rep_q   <= 1'b0;
            shreg_q <= '0;
            pal_q   <= '0;
            irq_n_q <= 1'b1;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            rep_q   <= rep_d;
            shreg_q <= shreg_d;
            pal_q   <= pal_d;
            irq_n_q <= irq_n_d;
        end
    end

    // Timing flags and colour are decoded straight from the registered state.
    always_comb begin
        hblank  = (int'(hcnt_q) >= H_ACTIVE);
        vblank  = (int'(vcnt_q) >= V_ACTIVE);
        hsync   = (int'(hcnt_q) >= H_SYNC_START) && (int'(hcnt_q) < H_SYNC_START + H_SYNC_LEN);
        vsync   = (int'(vcnt_q) >= V_SYNC_START) && (int'(vcnt_q) < V_SYNC_START + V_SYNC_LEN);
        csync_n = ~(hsync | vsync);
        pix_idx = shreg_q[7 -: BPP];
        rgb     = (hblank || vblank) ? 3'd0 : pal_q[int'(pix_idx) * 3 +: 3];
    end

    assign irq_n          = irq_n_q;
    assign hcnt           = hcnt_q;
    assign vcnt           = vcnt_q;
    assign vbus.vram_addr = addr_out;
    assign vbus.vram_sel  = slot;
    assign vbus.cpu_stall = slot;
endmodule

// File: tb/tb_dottori_video_gen.sv
// tb_dottori_video_gen
// Directed bench for dottori_video_gen. Instance A uses the default 256x256
// 1bpp timing; instance B is a small 64x16 frame with BPP=2, PIX_REP=2 so its
// second frame is reached quickly. Each instance has a registered-read VRAM.
module tb_dottori_video_gen;
    logic        nCLK_4M = 1'b0;
    logic        nRESET;
    logic        pal_wr, pal_wr_b;
    logic [5:0]  pal_data_a;
    logic [11:0] pal_data_b;

    logic [2:0]  rgb_a, rgb_b;
    logic        hsync_a, vsync_a, csync_n_a, hblank_a, vblank_a, irq_n_a;
    logic        hsync_b, vsync_b, csync_n_b, hblank_b, vblank_b, irq_n_b;
    logic [7:0]  hcnt_a, vcnt_a;
    logic [5:0]  hcnt_b;
    logic [3:0]  vcnt_b;

    logic [7:0]  mem_a [2048];
    logic [7:0]  mem_b [32];

    int vectors = 0;
    int miscompares = 0;

    dottori_video_gen_if #(.ADDR_W(11)) vbus_a ();
    dottori_video_gen_if #(.ADDR_W(5))  vbus_b ();

    always #5 nCLK_4M = ~nCLK_4M;

    // VRAM models: data appears the cycle after the address is presented.
    always @(posedge nCLK_4M) vbus_a.vram_q <= mem_a[vbus_a.vram_addr];
    always @(posedge nCLK_4M) vbus_b.vram_q <= mem_b[vbus_b.vram_addr];

    dottori_video_gen dut_a (
        .nCLK_4M (nCLK_4M),  .nRESET (nRESET),   .vbus (vbus_a),
        .pal_wr  (pal_wr),   .pal_data (pal_data_a), .rgb (rgb_a),
        .hsync   (hsync_a),  .vsync  (vsync_a),  .csync_n (csync_n_a),
        .hblank  (hblank_a), .vblank (vblank_a), .irq_n (irq_n_a),
        .hcnt    (hcnt_a),   .vcnt   (vcnt_a)
    );

    dottori_video_gen #(
        .H_TOTAL(64), .H_ACTIVE(32), .H_SYNC_START(40), .H_SYNC_LEN(8),
        .V_TOTAL(16), .V_ACTIVE(8),  .V_SYNC_START(10), .V_SYNC_LEN(2),
        .BPP(2), .PIX_REP(2), .ADDR_W(5)
    ) dut_b (
        .nCLK_4M (nCLK_4M),  .nRESET (nRESET),   .vbus (vbus_b),
        .pal_wr  (pal_wr_b), .pal_data (pal_data_b), .rgb (rgb_b),
        .hsync   (hsync_b),  .vsync  (vsync_b),  .csync_n (csync_n_b),
        .hblank  (hblank_b), .vblank (vblank_b), .irq_n (irq_n_b),
        .hcnt    (hcnt_b),   .vcnt   (vcnt_b)
    );

    task automatic tick();
        @(posedge nCLK_4M);
        @(negedge nCLK_4M);
    endtask

    task automatic applyStimulus(input logic wr, input logic [5:0] data);
        pal_wr     = wr;
        pal_data_a = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int h, v;
        int sel_cnt, sel_bad, b2b, hs_cnt, hs_bad, vs_cnt, vs_bad, cs_bad;
        int blank_bad, cnt_bad, irq_cnt, irq_first, max_addr;
        logic exp_sel, exp_hs, exp_vs, prev_sel;
        logic [2:0] rgb_a_exp [8];
        logic [2:0] rgb_b_exp [8];

        rgb_a_exp = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7, 3'd0, 3'd7};
        rgb_b_exp = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd7, 3'd7};
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        foreach (mem_b[i]) mem_b[i] = 8'h00;
        mem_a[0] = 8'hA5;
        mem_b[0] = 8'h1B;

        sel_cnt = 0; sel_bad = 0; b2b = 0; hs_cnt = 0; hs_bad = 0; vs_cnt = 0;
        vs_bad = 0; cs_bad = 0; blank_bad = 0; cnt_bad = 0; irq_cnt = 0;
        irq_first = -1; max_addr = 0; prev_sel = 1'b0;

        nRESET     = 1'b0;
        pal_wr_b   = 1'b0;
        pal_data_b = '0;
        applyStimulus(1'b0, 6'd0);
        repeat (3) tick();

        checkOutput("reset_hcnt", 32'(hcnt_a), 32'd0);
        checkOutput("reset_vcnt", 32'(vcnt_a), 32'd0);
        checkOutput("reset_sel", 32'(vbus_a.vram_sel), 32'd0);
        checkOutput("reset_addr", 32'(vbus_a.vram_addr), 32'd0);
        checkOutput("reset_irq_n", 32'(irq_n_a), 32'd1);
        checkOutput("reset_rgb", 32'(rgb_a), 32'd0);
        nRESET = 1'b1;

        // First frame of A (and the first frames of B), sampled every cycle.
        for (int cyc = 0; cyc < 65536; cyc++) begin
            h = cyc % 256;
            v = cyc / 256;
            exp_sel = (((v <= 126) || (v == 255)) && (h == 254)) ||
                      ((v <= 127) && (h <= 118) && ((h % 8) == 6));
            exp_hs  = (h >= 192) && (h < 208);
            exp_vs  = (v >= 224) && (v < 232);

            if (vbus_a.vram_sel) sel_cnt++;
            if (vbus_a.vram_sel !== exp_sel || vbus_a.cpu_stall !== exp_sel) sel_bad++;
            if (vbus_a.vram_sel && prev_sel) b2b++;
            prev_sel = vbus_a.vram_sel;
            if (vbus_a.vram_sel && int'(vbus_a.vram_addr) > max_addr && cyc < 65534)
                max_addr = int'(vbus_a.vram_addr);
            if (hsync_a) hs_cnt++;
            if (hsync_a !== exp_hs) hs_bad++;
            if (vsync_a) vs_cnt++;
            if (vsync_a !== exp_vs) vs_bad++;
            if (csync_n_a !== !(exp_hs || exp_vs)) cs_bad++;
            if (hblank_a !== (h >= 128) || vblank_a !== (v >= 128)) blank_bad++;
            if (hcnt_a !== 8'(h) || vcnt_a !== 8'(v)) cnt_bad++;
            if (irq_n_a === 1'b0) begin
                irq_cnt++;
                if (irq_first < 0) irq_first = cyc;
            end

            if (cyc == 3) begin
                applyStimulus(1'b1, 6'b111_000);
                pal_wr_b   = 1'b1;
                pal_data_b = {3'd7, 3'd4, 3'd2, 3'd1};
            end else if (cyc == 4) begin
                applyStimulus(1'b0, 6'b111_000);
                pal_wr_b = 1'b0;
            end

            // Frame 1 fetches are one byte behind, so byte 0 shows at column 8.
            if (cyc >= 8 && cyc <= 15)
                checkOutput("a_frame1_col8_rgb", 32'(rgb_a), 32'(rgb_a_exp[cyc - 8]));
            if (cyc == 1022) begin
                checkOutput("b_wrap_slot_sel", 32'(vbus_b.vram_sel), 32'd1);
                checkOutput("b_wrap_slot_addr", 32'(vbus_b.vram_addr), 32'd0);
            end
            if (cyc >= 1024 && cyc <= 1031)
                checkOutput("b_2bpp_rep2_rgb", 32'(rgb_b), 32'(rgb_b_exp[cyc - 1024]));
            if (cyc == 1494) begin
                checkOutput("b_last_slot_sel", 32'(vbus_b.vram_sel), 32'd1);
                checkOutput("b_last_slot_addr", 32'(vbus_b.vram_addr), 32'd31);
            end
            if (cyc == 65534) begin
                checkOutput("a_wrap_slot_sel", 32'(vbus_a.vram_sel), 32'd1);
                checkOutput("a_wrap_slot_addr", 32'(vbus_a.vram_addr), 32'd0);
            end
            tick();
        end

        checkOutput("a_sel_errors", 32'(sel_bad), 32'd0);
        checkOutput("a_sel_per_frame", 32'(sel_cnt), 32'd2048);
        checkOutput("a_back_to_back_stall", 32'(b2b), 32'd0);
        checkOutput("a_max_addr_frame1", 32'(max_addr), 32'd2046);
        checkOutput("a_hsync_errors", 32'(hs_bad), 32'd0);
        checkOutput("a_hsync_cycles", 32'(hs_cnt), 32'd4096);
        checkOutput("a_vsync_errors", 32'(vs_bad), 32'd0);
        checkOutput("a_vsync_cycles", 32'(vs_cnt), 32'd2048);
        checkOutput("a_csync_errors", 32'(cs_bad), 32'd0);
        checkOutput("a_blank_errors", 32'(blank_bad), 32'd0);
        checkOutput("a_counter_errors", 32'(cnt_bad), 32'd0);
        checkOutput("a_irq_low_cycles", 32'(irq_cnt), 32'd256);
        checkOutput("a_irq_first_cycle", 32'(irq_first), 32'd32768);
        checkOutput("a_frame_wrap_hcnt", 32'(hcnt_a), 32'd0);
        checkOutput("a_frame_wrap_vcnt", 32'(vcnt_a), 32'd0);

        // Second frame, line 0: prefetched byte 0, then a mid-line palette write.
        for (int k = 0; k < 40; k++) begin
            if (k <= 7)
                checkOutput("a_serialise_rgb", 32'(rgb_a), 32'(rgb_a_exp[k]));
            if (k == 6) begin
                checkOutput("a_frame2_slot1_sel", 32'(vbus_a.vram_sel), 32'd1);
                checkOutput("a_frame2_slot1_addr", 32'(vbus_a.vram_addr), 32'd1);
            end
            if (k == 20) begin
                checkOutput("a_pal_before_wr", 32'(rgb_a), 32'd0);
                applyStimulus(1'b1, 6'b111_101);
            end
            if (k == 21) begin
                applyStimulus(1'b0, 6'b111_101);
                checkOutput("a_pal_after_wr", 32'(rgb_a), 32'd5);
                checkOutput("a_pal_sel_h21", 32'(vbus_a.vram_sel), 32'd0);
            end
            if (k == 22) begin
                checkOutput("a_pal_sel_h22", 32'(vbus_a.vram_sel), 32'd1);
                checkOutput("a_pal_rgb_h22", 32'(rgb_a), 32'd5);
            end
            if (k == 30)
                checkOutput("a_pal_sel_h30", 32'(vbus_a.vram_sel), 32'd1);
            tick();
        end

        // Asynchronous reset in the middle of the line.
        checkOutput("a_pre_reset_rgb", 32'(rgb_a), 32'd5);
        nRESET = 1'b0;
        #1;
        checkOutput("async_reset_hcnt", 32'(hcnt_a), 32'd0);
        checkOutput("async_reset_vcnt", 32'(vcnt_a), 32'd0);
        checkOutput("async_reset_rgb", 32'(rgb_a), 32'd0);
        checkOutput("async_reset_irq_n", 32'(irq_n_a), 32'd1);
        checkOutput("async_reset_addr", 32'(vbus_a.vram_addr), 32'd0);
        checkOutput("async_reset_sel", 32'(vbus_a.vram_sel), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
